ilkn_lat_rx_checker: RTL and testbench
======================================

# ilkn_lat_rx_checker

Receive-side latency checker for the Interlaken latency-measurement design. Sits on the Interlaken RX user interface and parses probe packets emitted by the TX probe generator. From each packet it extracts the TX timestamp and sequence number, then computes one-way latency against the shared free-running timestamp counter. It accumulates min/max/sum/count statistics and sequence/format error counts for readout.

## Interface
Parameters:
- DATA_W, 128: RX data beat width in bits; must be at least 128.
- TS_W, 64: timestamp width.
- CNT_W, 32: width of the packet and error counters.
- SUM_W, 80: latency accumulator width.

Ports (one clock; reset is asynchronous and active-high):
- init_clk, in, 1: sole clock; RX bus and ts_now are synchronous to it.
- clk_reset, in, 1: asynchronous, active-high reset.
- rx_valid, in, 1: beat valid. There is no backpressure; the block always accepts.
- rx_sop, in, 1: first beat of packet.
- rx_eop, in, 1: last beat of packet.
- rx_err, in, 1: packet error flag from the core; sampled on the EOP beat.
- rx_data, in, DATA_W: beat data.
- ts_now, in, TS_W: shared free-running timestamp, the same counter the TX generator stamps with.
- stats_clr, in, 1: one-cycle synchronous clear of all statistics.
- lat_valid, out, 1: one-cycle pulse when lat_last is updated.
- lat_last, out, TS_W: latency of the most recent good-magic packet.
- lat_min, out, TS_W: minimum latency.
- lat_max, out, TS_W: maximum latency.
- lat_sum, out, SUM_W: sum of latencies.
- pkt_cnt, out, CNT_W: good packets counted.
- seq_err_cnt, out, CNT_W: sequence gaps or reorders.
- fmt_err_cnt, out, CNT_W: magic mismatches plus framing errors.
- crc_err_cnt, out, CNT_W: packets with rx_err set at EOP.

## Operation
- Probe format, SOP beat only:
  - rx_data[63:0] = TX timestamp (zero-extended or truncated to TS_W).
  - rx_data[95:64] = sequence number.
  - rx_data[127:96] = MAGIC, 32'hA5A5_1A7E.
  - All other beats are payload and are ignored.
- Framing FSM states are IDLE and BODY.
  - IDLE + valid&sop&!eop -> BODY.
  - IDLE + valid&sop&eop is a one-beat packet; the FSM stays in IDLE.
  - IDLE + valid&!sop is an orphan beat: fmt_err_cnt++, stay in IDLE.
  - BODY + valid&eop -> IDLE.
  - BODY + valid&sop is a missing EOP: fmt_err_cnt++, and the beat is processed as a new SOP (next state follows its eop bit).
- On each SOP beat with matching MAGIC:
  - lat = ts_now - tx_ts, modulo 2^TS_W, so counter wrap is handled by the wrap-around subtraction.
  - lat_last is updated and lat_valid pulses.
  - lat_min = min, lat_max = max, lat_sum += lat (saturating), pkt_cnt++ (saturating).
- On an SOP beat with a MAGIC mismatch: fmt_err_cnt++. No latency update and no sequence check.
- Sequence check on good-magic packets:
  - The first packet after reset or stats_clr only loads exp_seq = seq+1.
  - Afterwards, seq != exp_seq -> seq_err_cnt++, and exp_seq resynchronises to seq+1.
  - Sequence numbers wrap modulo 2^32.
- crc_err_cnt increments on a valid&eop beat with rx_err=1. The latency already taken at SOP is kept.
- All counters saturate at all-ones; they never wrap.
- stats_clr:
  - Zeroes lat_sum, pkt_cnt and all error counters.
  - Sets lat_min to all-ones and lat_max to 0, and rearms the first-packet sequence load.
  - It has priority: a packet event in the same cycle is not counted and does not update any statistic. The FSM still tracks framing.
  - lat_last is not cleared.

## Timing
- Reset values:
  - FSM = IDLE.
  - lat_valid=0 and lat_last=0.
  - lat_min = all-ones, lat_max=0, lat_sum=0.
  - All counters = 0; first-packet flag armed.
- ts_now is sampled in the same cycle as the SOP beat.
- lat_valid and lat_last are registered 1 cycle after the SOP beat.
- lat_min, lat_max, lat_sum and pkt_cnt update 2 cycles after the SOP beat (1 compare/add stage).
- Error counters update 1 cycle after the offending beat.
- Back-to-back SOP beats every cycle are supported at full rate.
- Reset mid-packet returns the FSM to IDLE immediately. The next beat without SOP counts as an orphan.

## Structure
- Package ilkn_lat_pkg holds:
  - MAGIC, with field offsets TS_LSB=0, SEQ_LSB=64 and MAGIC_LSB=96.
  - The state typedef {IDLE, BODY}.
  - A saturating-increment function.
- Sub-module ilkn_lat_stats covers the latency pipeline stage, min/max/sum, pkt_cnt and clear handling.
- The top level contains the framing FSM, field extract, sequence check and error counters.

## Test plan
- Reset, then 3 one-beat probes with seq 0,1,2 and latencies 10, 25, 17 -> lat_min=10, lat_max=25, lat_sum=52, pkt_cnt=3, seq_err_cnt=0; lat_valid pulses 3 times.
- ts_now=5 with tx_ts=2^64-3 -> lat_last=8 (wrap-around).
- Probes with seq 0,1,3,2 -> seq_err_cnt=2; exp_seq after the last probe = 3.
- 4-beat packet with bad MAGIC, then a beat with sop in BODY, then an orphan beat in IDLE -> fmt_err_cnt=3, pkt_cnt unchanged.
- Good packet with rx_err=1 on EOP -> crc_err_cnt=1, pkt_cnt=1.
- stats_clr on the same cycle as a good SOP -> all counters 0, lat_min=all-ones, lat_max=0; the next probe is treated as first (no seq error).

Source files
------------

// File: rtl/ilkn_lat_pkg.sv
// ilkn_lat_pkg: shared constants, types and helpers for the Interlaken
// RX latency checker.
//   MAGIC / *_LSB : probe header layout on the SOP beat
//   frame_state_t : framing FSM state encoding
//   sat_inc       : width-generic saturating increment
package ilkn_lat_pkg;

  localparam logic [31:0] MAGIC      = 32'hA5A5_1A7E;
  localparam int unsigned TS_LSB     = 0;
  localparam int unsigned SEQ_LSB    = 64;
  localparam int unsigned MAGIC_LSB  = 96;
  localparam int unsigned FIELD_TS_W = 64;
  localparam int unsigned SEQ_W      = 32;
  localparam int unsigned MAGIC_W    = 32;
  localparam int unsigned SAT_MAX_W  = 128;

  typedef enum logic {
    IDLE,
    BODY
  } frame_state_t;

  // Increment the low w bits of v, holding at all-ones instead of wrapping.
  // Callers widen their counter to SAT_MAX_W and narrow the result back.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int unsigned w);
    logic [SAT_MAX_W-1:0] mask;
    mask = '1;
    if (w < SAT_MAX_W) mask = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
    if ((v & mask) == mask) return v;
    return v + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/ilkn_lat_rx_checker_if.sv
// ilkn_lat_rx_checker_if: Interlaken RX user-interface beat bus.
//   rx_valid : beat valid (no backpressure)
//   rx_sop   : first beat of packet
//   rx_eop   : last beat of packet
//   rx_err   : packet error flag, meaningful on the EOP beat
//   rx_data  : beat data
// master drives the bus (core / testbench), slave receives it (checker).
interface ilkn_lat_rx_checker_if #(
  parameter int unsigned DATA_W = 128
);
  logic              rx_valid;
  logic              rx_sop;
  logic              rx_eop;
  logic              rx_err;
  logic [DATA_W-1:0] rx_data;

  modport master (output rx_valid, rx_sop, rx_eop, rx_err, rx_data);
  modport slave  (input  rx_valid, rx_sop, rx_eop, rx_err, rx_data);
endinterface

// File: rtl/ilkn_lat_stats.sv
// ilkn_lat_stats: latency pipeline stage and statistics accumulators.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear of min/max/sum/count
//   in_valid   : a good probe was seen this cycle (already gated by clr)
//   in_lat     : its latency
//   lat_valid  : registered in_valid (one-cycle pulse)
//   lat_last   : registered latency of the latest good probe
//   lat_min/lat_max/lat_sum/pkt_cnt : statistics, one stage after lat_last
module ilkn_lat_stats
  import ilkn_lat_pkg::*;
#(
  parameter int unsigned TS_W  = 64,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SUM_W = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [TS_W-1:0]  in_lat,
  output logic             lat_valid,
  output logic [TS_W-1:0]  lat_last,
  output logic [TS_W-1:0]  lat_min,
  output logic [TS_W-1:0]  lat_max,
  output logic [SUM_W-1:0] lat_sum,
  output logic [CNT_W-1:0] pkt_cnt
);

  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_nxt;

  // Carry out of the widened add means overflow: clamp to all-ones.
  always_comb begin
    sum_ext = {1'b0, lat_sum} + (SUM_W+1)'(lat_last);
    sum_nxt = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_valid <= 1'b0;
      lat_last  <= '0;
    end else begin
      lat_valid <= in_valid;
      if (in_valid) lat_last <= in_lat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_min <= '1;
      lat_max <= '0;
      lat_sum <= '0;
      pkt_cnt <= '0;
    end else if (clr) begin
      lat_min <= '1;
      lat_max <= '0;
      lat_sum <= '0;
      pkt_cnt <= '0;
    end else if (lat_valid) begin
      if (lat_last < lat_min) lat_min <= lat_last;
      if (lat_last > lat_max) lat_max <= lat_last;
      lat_sum <= sum_nxt;
      pkt_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(pkt_cnt), CNT_W));
    end
  end

endmodule

// File: rtl/ilkn_lat_rx_checker.sv
// ilkn_lat_rx_checker: RX-side probe parser and one-way latency checker.
//   init_clk, clk_reset : clock, asynchronous active-high reset
//   rx (slave)          : Interlaken RX beat bus
//   ts_now              : shared free-running timestamp
//   stats_clr           : one-cycle synchronous statistics clear
//   lat_valid/lat_last  : per-probe latency, one cycle after SOP
//   lat_min/max/sum, pkt_cnt : statistics, two cycles after SOP
//   seq_err_cnt, fmt_err_cnt, crc_err_cnt : error counters
module ilkn_lat_rx_checker
  import ilkn_lat_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned TS_W   = 64,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned SUM_W  = 80
) (
  input  logic                  init_clk,
  input  logic                  clk_reset,
  ilkn_lat_rx_checker_if.slave  rx,
  input  logic [TS_W-1:0]       ts_now,
  input  logic                  stats_clr,
  output logic                  lat_valid,
  output logic [TS_W-1:0]       lat_last,
  output logic [TS_W-1:0]       lat_min,
  output logic [TS_W-1:0]       lat_max,
  output logic [SUM_W-1:0]      lat_sum,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      seq_err_cnt,
  output logic [CNT_W-1:0]      fmt_err_cnt,
  output logic [CNT_W-1:0]      crc_err_cnt
);

  frame_state_t      state, state_nxt;
  logic [DATA_W-1:0] beat_data;
  logic [TS_W-1:0]   tx_ts;
  logic [TS_W-1:0]   lat_calc;
  logic [SEQ_W-1:0]  seq;
  logic [SEQ_W-1:0]  exp_seq;
  logic              seq_first;
  logic              beat_sop, magic_ok, bad_magic, good_sop;
  logic              orphan, missing_eop, crc_ev;
  logic [CNT_W-1:0]  fmt_a, fmt_nxt;

  assign beat_data = rx.rx_data;
  assign tx_ts     = TS_W'(beat_data[TS_LSB +: FIELD_TS_W]);
  assign seq       = beat_data[SEQ_LSB +: SEQ_W];
  assign magic_ok  = (beat_data[MAGIC_LSB +: MAGIC_W] == MAGIC);
  assign lat_calc  = ts_now - tx_ts;

  // Any SOP beat is parsed as a probe header, whatever the framing state.
  assign beat_sop  = rx.rx_valid & rx.rx_sop;
  assign bad_magic = beat_sop & ~magic_ok;
  assign good_sop  = beat_sop & magic_ok & ~stats_clr;
  assign crc_ev    = rx.rx_valid & rx.rx_eop & rx.rx_err;

  always_ff @(posedge init_clk or posedge clk_reset) begin
    if (clk_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    orphan      = 1'b0;
    missing_eop = 1'b0;
    case (state)
      IDLE: begin
        if (rx.rx_valid) begin
          if (rx.rx_sop) state_nxt = rx.rx_eop ? IDLE : BODY;
          else           orphan    = 1'b1;
        end
      end
      BODY: begin
        if (rx.rx_valid) begin
          if (rx.rx_sop) begin
            missing_eop = 1'b1;
            state_nxt   = rx.rx_eop ? IDLE : BODY;
          end else if (rx.rx_eop) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A beat can raise two format events (missing EOP and bad magic); each counts.
  always_comb begin
    fmt_a   = fmt_err_cnt;
    fmt_nxt = fmt_err_cnt;
    if (orphan | missing_eop) fmt_a = CNT_W'(sat_inc(SAT_MAX_W'(fmt_err_cnt), CNT_W));
    fmt_nxt = fmt_a;
    if (bad_magic) fmt_nxt = CNT_W'(sat_inc(SAT_MAX_W'(fmt_a), CNT_W));
  end

  always_ff @(posedge init_clk or posedge clk_reset) begin
    if (clk_reset) begin
      fmt_err_cnt <= '0;
      crc_err_cnt <= '0;
    end else if (stats_clr) begin
      fmt_err_cnt <= '0;
      crc_err_cnt <= '0;
    end else begin
      fmt_err_cnt <= fmt_nxt;
      if (crc_ev) crc_err_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(crc_err_cnt), CNT_W));
    end
  end

  always_ff @(posedge init_clk or posedge clk_reset) begin
    if (clk_reset) begin
      seq_first   <= 1'b1;
      exp_seq     <= '0;
      seq_err_cnt <= '0;
    end else if (stats_clr) begin
      seq_first   <= 1'b1;
      seq_err_cnt <= '0;
    end else if (good_sop) begin
      seq_first <= 1'b0;
      exp_seq   <= seq + SEQ_W'(1);
      if (!seq_first && (seq != exp_seq))
        seq_err_cnt <= CNT_W'(sat_inc(SAT_MAX_W'(seq_err_cnt), CNT_W));
    end
  end

  ilkn_lat_stats #(
    .TS_W  (TS_W),
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) u_stats (
    .clk       (init_clk),
    .rst       (clk_reset),
    .clr       (stats_clr),
    .in_valid  (good_sop),
    .in_lat    (lat_calc),
    .lat_valid (lat_valid),
    .lat_last  (lat_last),
    .lat_min   (lat_min),
    .lat_max   (lat_max),
    .lat_sum   (lat_sum),
    .pkt_cnt   (pkt_cnt)
  );

endmodule

// File: tb/tb_ilkn_lat_rx_checker.sv
// tb_ilkn_lat_rx_checker: self-checking bench for ilkn_lat_rx_checker.
module tb_ilkn_lat_rx_checker;

  localparam logic [31:0] MG  = 32'hA5A5_1A7E;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         init_clk = 1'b0;
  logic         clk_reset = 1'b1;
  logic [63:0]  ts_now = '0;
  logic         stats_clr = 1'b0;
  logic         lat_valid;
  logic [63:0]  lat_last, lat_min, lat_max;
  logic [79:0]  lat_sum;
  logic [31:0]  pkt_cnt, seq_err_cnt, fmt_err_cnt, crc_err_cnt;

  int unsigned  checks = 0;
  int unsigned  failures = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  lat_e;

  typedef struct {
    logic        vld, sop, eop, err, clr;
    logic [31:0] magic, seq;
    logic [63:0] tx, now;
    logic        has_lat;
    logic [63:0] exp_lat;
    logic        chk;
    logic [31:0] e_pkt, e_seq, e_fmt, e_crc;
    logic [63:0] e_min, e_max;
    logic [79:0] e_sum;
  } vec_t;

  vec_t tbl[$];

  ilkn_lat_rx_checker_if #(.DATA_W(128)) rx_if ();

  ilkn_lat_rx_checker #(
    .DATA_W (128),
    .TS_W   (64),
    .CNT_W  (32),
    .SUM_W  (80)
  ) dut (
    .init_clk    (init_clk),
    .clk_reset   (clk_reset),
    .rx          (rx_if),
    .ts_now      (ts_now),
    .stats_clr   (stats_clr),
    .lat_valid   (lat_valid),
    .lat_last    (lat_last),
    .lat_min     (lat_min),
    .lat_max     (lat_max),
    .lat_sum     (lat_sum),
    .pkt_cnt     (pkt_cnt),
    .seq_err_cnt (seq_err_cnt),
    .fmt_err_cnt (fmt_err_cnt),
    .crc_err_cnt (crc_err_cnt)
  );

  always #5 init_clk = ~init_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each lat_valid pulse must match the oldest queued expectation.
  always @(negedge init_clk) begin
    if (!clk_reset && lat_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL lat_valid_unexpected actual=1 required=0 lat_last=%0h", lat_last);
      end else begin
        lat_e = exp_q.pop_front();
        chk("lat_last", {64'd0, lat_last}, {64'd0, lat_e});
      end
    end
  end

  task automatic set_idle();
    rx_if.rx_valid = 1'b0;
    rx_if.rx_sop   = 1'b0;
    rx_if.rx_eop   = 1'b0;
    rx_if.rx_err   = 1'b0;
    rx_if.rx_data  = '0;
    stats_clr      = 1'b0;
  endtask

  task automatic add_beat(input logic vld, sop, eop, err, clr,
                          input logic [31:0] magic, seq,
                          input logic [63:0] tx, now,
                          input logic has_lat, input logic [63:0] exp_lat);
    vec_t v;
    v = '{vld:vld, sop:sop, eop:eop, err:err, clr:clr, magic:magic, seq:seq,
          tx:tx, now:now, has_lat:has_lat, exp_lat:exp_lat, chk:1'b0,
          e_pkt:'0, e_seq:'0, e_fmt:'0, e_crc:'0, e_min:'0, e_max:'0, e_sum:'0};
    tbl.push_back(v);
  endtask

  task automatic add_chk(input logic [31:0] pkt, seqe, fmt, crc,
                         input logic [63:0] mn, mx, input logic [79:0] sm);
    int unsigned last;
    last = tbl.size() - 1;
    tbl[last].chk   = 1'b1;
    tbl[last].e_pkt = pkt;
    tbl[last].e_seq = seqe;
    tbl[last].e_fmt = fmt;
    tbl[last].e_crc = crc;
    tbl[last].e_min = mn;
    tbl[last].e_max = mx;
    tbl[last].e_sum = sm;
  endtask

  task automatic check_stats(input string tag, input logic [31:0] pkt, seqe, fmt, crc,
                             input logic [63:0] mn, mx, input logic [79:0] sm);
    chk({tag, ".pkt_cnt"},     {96'd0, pkt_cnt},     {96'd0, pkt});
    chk({tag, ".seq_err_cnt"}, {96'd0, seq_err_cnt}, {96'd0, seqe});
    chk({tag, ".fmt_err_cnt"}, {96'd0, fmt_err_cnt}, {96'd0, fmt});
    chk({tag, ".crc_err_cnt"}, {96'd0, crc_err_cnt}, {96'd0, crc});
    chk({tag, ".lat_min"},     {64'd0, lat_min},     {64'd0, mn});
    chk({tag, ".lat_max"},     {64'd0, lat_max},     {64'd0, mx});
    chk({tag, ".lat_sum"},     {48'd0, lat_sum},     {48'd0, sm});
  endtask

  task automatic pulse_reset();
    @(negedge init_clk);
    clk_reset = 1'b1;
    set_idle();
    @(posedge init_clk);
    @(posedge init_clk);
    #1 clk_reset = 1'b0;
  endtask

  initial begin
    set_idle();

    // Reset values while reset is held.
    repeat (3) @(posedge init_clk);
    @(negedge init_clk);
    chk("rst.lat_valid", {127'd0, lat_valid}, 128'd0);
    chk("rst.lat_last", {64'd0, lat_last}, 128'd0);
    check_stats("rst", 0, 0, 0, 0, ONES64, 64'd0, 80'd0);
    @(posedge init_clk);
    #1 clk_reset = 1'b0;

    // Reset mid-packet: FSM must be back in IDLE, so a non-SOP beat is an orphan.
    @(posedge init_clk); #1;
    rx_if.rx_valid = 1'b1; rx_if.rx_sop = 1'b1; rx_if.rx_eop = 1'b0;
    rx_if.rx_data  = {BAD, 32'd0, 64'd0};
    @(posedge init_clk); #1;
    set_idle();
    @(posedge init_clk); #3;
    clk_reset = 1'b1;
    #4 clk_reset = 1'b0;
    @(posedge init_clk); #1;
    rx_if.rx_valid = 1'b1; rx_if.rx_sop = 1'b0; rx_if.rx_eop = 1'b1;
    rx_if.rx_data  = 128'h1234;
    @(posedge init_clk); #1;
    set_idle();
    @(negedge init_clk);
    chk("midrst.fmt_err_cnt", {96'd0, fmt_err_cnt}, 128'd1);

    pulse_reset();

    // Three back-to-back one-beat probes, latencies 10/25/17.
    add_beat(1,1,1,0,0, MG, 32'd0, 64'd100, 64'd110, 1, 64'd10);
    add_beat(1,1,1,0,0, MG, 32'd1, 64'd200, 64'd225, 1, 64'd25);
    add_beat(1,1,1,0,0, MG, 32'd2, 64'd300, 64'd317, 1, 64'd17);
    add_chk(3, 0, 0, 0, 64'd10, 64'd25, 80'd52);
    // Timestamp counter wrap.
    add_beat(1,1,1,0,0, MG, 32'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1, 64'd8);
    add_chk(4, 0, 0, 0, 64'd8, 64'd25, 80'd60);
    // Clear, then sequence 0,1,3,2 then 3.
    add_beat(0,0,0,0,1, 32'd0, 32'd0, 64'd0, 64'd0, 0, 64'd0);
    add_chk(0, 0, 0, 0, ONES64, 64'd0, 80'd0);
    add_beat(1,1,1,0,0, MG, 32'd0, 64'd1000, 64'd1004, 1, 64'd4);
    add_beat(1,1,1,0,0, MG, 32'd1, 64'd1000, 64'd1004, 1, 64'd4);
    add_beat(1,1,1,0,0, MG, 32'd3, 64'd1000, 64'd1004, 1, 64'd4);
    add_beat(1,1,1,0,0, MG, 32'd2, 64'd1000, 64'd1004, 1, 64'd4);
    add_chk(4, 2, 0, 0, 64'd4, 64'd4, 80'd16);
    add_beat(1,1,1,0,0, MG, 32'd3, 64'd2000, 64'd2004, 1, 64'd4);
    add_chk(5, 2, 0, 0, 64'd4, 64'd4, 80'd20);
    // Four-beat bad-magic packet.
    add_beat(1,1,0,0,0, BAD, 32'd9, 64'd50, 64'd60, 0, 64'd0);
    add_beat(1,0,0,0,0, 32'h0, 32'h5555, 64'h77, 64'd61, 0, 64'd0);
    add_beat(1,0,0,0,0, 32'h0, 32'h6666, 64'h88, 64'd62, 0, 64'd0);
    add_beat(1,0,1,0,0, 32'h0, 32'h7777, 64'h99, 64'd63, 0, 64'd0);
    add_chk(5, 2, 1, 0, 64'd4, 64'd4, 80'd20);
    // Good SOP into BODY, then SOP while in BODY (missing EOP), then orphan.
    add_beat(1,1,0,0,0, MG, 32'd4, 64'd3000, 64'd3006, 1, 64'd6);
    add_beat(1,1,1,0,0, MG, 32'd5, 64'd3010, 64'd3016, 1, 64'd6);
    add_beat(1,0,1,0,0, 32'h0, 32'h0, 64'h0, 64'd3020, 0, 64'd0);
    add_chk(7, 2, 3, 0, 64'd4, 64'd6, 80'd32);
    // Good packet flagged bad at EOP: latency kept, crc counted.
    add_beat(1,1,0,0,0, MG, 32'd6, 64'd4000, 64'd4009, 1, 64'd9);
    add_beat(1,0,1,1,0, 32'h0, 32'h0, 64'h0, 64'd4010, 0, 64'd0);
    add_chk(8, 2, 3, 1, 64'd4, 64'd9, 80'd41);
    // Clear coincident with a good SOP: the packet is dropped from statistics.
    add_beat(1,1,1,0,1, MG, 32'd7, 64'd5000, 64'd5050, 0, 64'd0);
    add_chk(0, 0, 0, 0, ONES64, 64'd0, 80'd0);
    // Next probe is first after clear: arbitrary seq, no error.
    add_beat(1,1,1,0,0, MG, 32'd100, 64'd6000, 64'd6003, 1, 64'd3);
    add_chk(1, 0, 0, 0, 64'd3, 64'd3, 80'd3);

    foreach (tbl[i]) begin
      @(posedge init_clk); #1;
      rx_if.rx_valid = tbl[i].vld;
      rx_if.rx_sop   = tbl[i].sop;
      rx_if.rx_eop   = tbl[i].eop;
      rx_if.rx_err   = tbl[i].err;
      rx_if.rx_data  = {tbl[i].magic, tbl[i].seq, tbl[i].tx};
      ts_now         = tbl[i].now;
      stats_clr      = tbl[i].clr;
      if (tbl[i].has_lat) exp_q.push_back(tbl[i].exp_lat);
      if (tbl[i].chk) begin
        @(posedge init_clk); #1;
        set_idle();
        @(posedge init_clk);
        @(negedge init_clk);
        check_stats($sformatf("vec%0d", i), tbl[i].e_pkt, tbl[i].e_seq, tbl[i].e_fmt,
                    tbl[i].e_crc, tbl[i].e_min, tbl[i].e_max, tbl[i].e_sum);
      end
    end

    @(posedge init_clk); #1;
    set_idle();
    repeat (4) @(posedge init_clk);
    @(negedge init_clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
